// File: rtl/stopwatch_pkg_57.sv
// stopwatch_pkg_57: shared state encoding and default sizing for the stopwatch controller
package stopwatch_pkg_57;
  localparam int LAP_DEPTH_DEF = 5;
  localparam int ADDR_W_DEF = 3;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    RECALL = 2'd3
  } state_t;
endpackage

// File: rtl/stopwatch_ctrl_57_key_edge.sv
// key_edge_57: four-key rising-edge detector whose history resets high so held keys stay silent
module key_edge_57 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keys_i,
  output logic [3:0] edges_o
);
  logic [3:0] prev_q, prev_d;
  // previous key levels always track the inputs
  always_comb prev_d = keys_i;
  // history register, set to all-ones on reset
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 4'hF;
    else prev_q <= prev_d;
  end
  assign edges_o = keys_i & ~prev_q;
endmodule

// File: rtl/stopwatch_ctrl_57.sv
// stopwatch_ctrl_57: run/pause/recall sequencer with lap pointer and recall read-back
module stopwatch_ctrl_57
  import stopwatch_pkg_57::*;
#(
  parameter int LAP_DEPTH = LAP_DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_50m_57,
  input  logic              rst_n_57,
  input  logic              mode_en_57,
  input  logic              tick_100hz_57,
  input  logic              key_run_stop_57,
  input  logic              key_record_57,
  input  logic              key_rst_57,
  input  logic              key_recall_57,
  output logic              count_step_57,
  output logic              count_clr_57,
  output logic              write_e_57,
  output logic [ADDR_W-1:0] write_addr_57,
  output logic [ADDR_W-1:0] read_addr_57,
  output logic [ADDR_W-1:0] lap_count_57,
  output logic              recall_active_57,
  output logic [1:0]        state_57
);
  localparam logic [ADDR_W:0]   DEP  = (ADDR_W+1)'(LAP_DEPTH);
  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(LAP_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAP_DEPTH - 1);

  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] oldest(input logic [ADDR_W-1:0] w, input logic [ADDR_W-1:0] c);
    logic [ADDR_W:0] d;
    d = {1'b0, w} - {1'b0, c};
    return d[ADDR_W] ? ADDR_W'(d + DEP) : d[ADDR_W-1:0];
  endfunction

  logic [3:0] edges, act;
  logic       a_rst, a_run, a_rec, a_rcl, has_laps, last_lap;
  state_t     state_q, state_d, ret_q, ret_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, write_addr_q, write_addr_d;
  logic [ADDR_W-1:0] read_addr_q, read_addr_d, lap_q, lap_d, idx_q, idx_d;
  logic       step_q, step_d, clr_q, clr_d, we_q, we_d;

  key_edge_57 u_key_edge (
    .clk    (clk_50m_57),
    .rst_n  (rst_n_57),
    .keys_i ({key_recall_57, key_record_57, key_run_stop_57, key_rst_57}),
    .edges_o(edges)
  );

  assign act      = mode_en_57 ? edges : 4'b0;
  assign a_rst    = act[0];
  assign a_run    = act[1] & ~act[0];
  assign a_rec    = act[2] & ~|act[1:0];
  assign a_rcl    = act[3] & ~|act[2:0];
  assign has_laps = lap_q != '0;
  assign last_lap = idx_q == lap_q - 1'b1;

  // next-state, lap pointer and recall sequencing; one action per cycle
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    wr_ptr_d    = wr_ptr_q;
    lap_d       = lap_q;
    read_addr_d = read_addr_q;
    idx_d       = idx_q;
    clr_d       = 1'b0;
    we_d        = 1'b0;
    step_d      = tick_100hz_57 & (state_q == RUN);
    case (state_q)
      IDLE: begin
        if (a_run) state_d = RUN;
        else if (a_rst) clr_d = 1'b1;
        else if (a_rcl && has_laps) begin
          ret_d       = IDLE;
          state_d     = RECALL;
          idx_d       = '0;
          read_addr_d = oldest(wr_ptr_q, lap_q);
        end
      end
      RUN: begin
        if (a_run) state_d = PAUSE;
        else if (a_rec) begin
          we_d     = 1'b1;
          wr_ptr_d = inc(wr_ptr_q);
          lap_d    = (lap_q == FULL) ? lap_q : lap_q + 1'b1;
        end
      end
      PAUSE: begin
        if (a_run) state_d = RUN;
        else if (a_rst) begin
          clr_d       = 1'b1;
          lap_d       = '0;
          wr_ptr_d    = '0;
          read_addr_d = '0;
          state_d     = IDLE;
        end else if (a_rcl && has_laps) begin
          ret_d       = PAUSE;
          state_d     = RECALL;
          idx_d       = '0;
          read_addr_d = oldest(wr_ptr_q, lap_q);
        end
      end
      default: begin
        if (a_rst) begin
          clr_d       = 1'b1;
          lap_d       = '0;
          wr_ptr_d    = '0;
          read_addr_d = '0;
          state_d     = IDLE;
        end else if (a_run || (a_rcl && last_lap)) begin
          state_d     = ret_q;
          read_addr_d = '0;
        end else if (a_rcl) begin
          idx_d       = idx_q + 1'b1;
          read_addr_d = inc(read_addr_q);
        end
      end
    endcase
    write_addr_d = we_d ? wr_ptr_q : wr_ptr_d;
  end

  // registered state and outputs with synchronous active-low reset
  always_ff @(posedge clk_50m_57) begin
    if (!rst_n_57) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      wr_ptr_q     <= '0;
      write_addr_q <= '0;
      read_addr_q  <= '0;
      lap_q        <= '0;
      idx_q        <= '0;
      step_q       <= 1'b0;
      clr_q        <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      wr_ptr_q     <= wr_ptr_d;
      write_addr_q <= write_addr_d;
      read_addr_q  <= read_addr_d;
      lap_q        <= lap_d;
      idx_q        <= idx_d;
      step_q       <= step_d;
      clr_q        <= clr_d;
      we_q         <= we_d;
    end
  end

  assign count_step_57    = step_q;
  assign count_clr_57     = clr_q;
  assign write_e_57       = we_q;
  assign write_addr_57    = write_addr_q;
  assign read_addr_57     = read_addr_q;
  assign lap_count_57     = lap_q;
  assign recall_active_57 = state_q == RECALL;
  assign state_57         = state_q;
endmodule

// File: doc/stopwatch_ctrl_57.md
Name: stopwatch_ctrl_57

Overview:
- Single-clock sequencer for the stopwatch datapath, which comprises the time counter, the lap-record register file and the display select.
- Turns debounced key levels into one-cycle action pulses.
- Owns the run/pause/recall state machine.
- Generates the count-step enable from the 100 Hz tick.
- Schedules lap writes into a circular LAP_DEPTH-entry register file.
- Sequences read-back of stored laps for display recall, from oldest to newest.

Parameters:
- LAP_DEPTH, 5, number of lap-record slots; legal range is 2 to 7.
- ADDR_W, 3, width of write and read addresses and of the lap count.

Ports:
- clk_50m_57 in 1: system clock; the only clock.
- rst_n_57 in 1: reset, synchronous, active-low.
- mode_en_57 in 1: stopwatch mode is selected; key actions are accepted only while high.
- tick_100hz_57 in 1: one-cycle pulse every 10 ms.
- key_run_stop_57 in 1: debounced level for start/stop.
- key_record_57 in 1: debounced level for lap.
- key_rst_57 in 1: debounced level for clear.
- key_recall_57 in 1: debounced level for lap recall/step.
- count_step_57 out 1: advance the time counter by 1/100 s.
- count_clr_57 out 1: one-cycle pulse that zeroes the time counter.
- write_e_57 out 1: one-cycle lap-write strobe.
- write_addr_57 out ADDR_W: lap slot written while write_e_57 is high; otherwise the next slot.
- read_addr_57 out ADDR_W: lap slot shown during recall.
- lap_count_57 out ADDR_W: number of valid laps, 0 to LAP_DEPTH.
- recall_active_57 out 1: display shows read_addr_57 instead of the live time.
- state_57 out 2: current FSM state, for debug and LED output.

Behaviour:
- Reset (rst_n_57 low at a clock edge): state is IDLE. All outputs are 0. The previous-key registers are set to 1, so a key held through reset does not fire an action.
- Edge detection: action = key & ~key_prev. Key inputs are already synchronous.
- Only one action is taken per cycle. Priority order is rst, then run_stop, then record, then recall; lower-priority edges in the same cycle are dropped.
- While mode_en_57 is low, all actions are ignored and key_prev keeps tracking the keys. The state is held. In RUN, counting continues in the background.
- Latency: every output is registered. It changes on the clock edge that samples the key edge or the tick.
- count_step_57 <= tick_100hz_57 & (state == RUN). The state used is the current state, before any transition in the same cycle.
- States: IDLE=0, RUN=1, PAUSE=2, RECALL=3.
- IDLE:
  - run_stop goes to RUN.
  - rst pulses count_clr_57 and stays in IDLE.
  - recall goes to RECALL if lap_count_57 > 0; otherwise it is ignored.
  - record is ignored.
- RUN:
  - run_stop goes to PAUSE.
  - record writes a lap and stays in RUN.
  - rst and recall are ignored.
- PAUSE:
  - run_stop goes to RUN.
  - rst pulses count_clr_57, clears lap_count_57 and write_addr_57 to 0, and goes to IDLE.
  - recall goes to RECALL if lap_count_57 > 0.
  - record is ignored.
- RECALL:
  - The entry state (IDLE or PAUSE) is saved in ret_state.
  - recall steps to the next lap. After the newest lap it exits to ret_state.
  - run_stop exits to ret_state with no counting change.
  - rst does the full clear, as in PAUSE, and goes to IDLE.
  - recall_active_57 is 1 only in RECALL.
- Lap write:
  - write_e_57 = 1 for exactly one cycle, with write_addr_57 equal to the target slot.
  - On the next cycle write_addr_57 = (addr + 1) mod LAP_DEPTH, wrapping from LAP_DEPTH-1 to 0.
  - lap_count_57 increments and saturates at LAP_DEPTH; the oldest lap is overwritten.
- Recall sequencing:
  - On entry, read_addr_57 = (write_addr_57 - lap_count_57) mod LAP_DEPTH (the oldest lap) and recall_idx = 0.
  - On each recall edge: if recall_idx == lap_count_57 - 1, exit; otherwise recall_idx++ and read_addr_57 = (read_addr_57 + 1) mod LAP_DEPTH.
  - On exit, read_addr_57 is 0.
- Modular subtraction: add LAP_DEPTH when the difference is negative. No out-of-range address is ever driven.
- Reset mid-operation, including mid-recall: returns to the reset values regardless of state.

Decomposition:
- Package stopwatch_pkg_57 holds:
  - the state encoding constants IDLE, RUN, PAUSE and RECALL;
  - LAP_DEPTH_DEF = 5 and ADDR_W_DEF = 3.
- One sub-module, key_edge_57: a four-key rising-edge detector with the key_prev registers resetting to 1. It is instantiated once.
- The FSM, lap pointer and recall sequencer stay in stopwatch_ctrl_57.

Test Plan:
- Reset with key_run_stop_57 held high, then release reset -> state_57=0, all outputs 0, no RUN entry until the key falls and rises again.
- run_stop edge, then 3 ticks, then run_stop edge, then 2 ticks -> state 1 then 2; exactly 3 count_step_57 pulses, each 1 cycle after its tick; none while in PAUSE.
- In RUN, 6 record edges -> write_e_57 pulses with write_addr_57 = 0,1,2,3,4,0; lap_count_57 = 1,2,3,4,5,5.
- After the 6 laps, stop, then 6 recall edges -> read_addr_57 = 1,2,3,4,0 while recall_active_57=1; the 6th recall edge returns to PAUSE (state 2) with recall_active_57=0.
- In PAUSE, rst and run_stop edges in the same cycle -> count_clr_57 pulses once, state IDLE, lap_count_57=0, write_addr_57=0, no RUN entry.
- In RUN, drop mode_en_57 and press all keys -> no state change, count_step_57 still follows ticks. Enter RECALL, then assert rst_n_57 low for 1 cycle -> IDLE, recall_active_57=0.
